// File: rtl/mem_wb_stage.sv
// mem_wb_stage: FP pipeline memory/write-back stage with single-entry buffer, FLW/FSW on a req/ack port and timeout.
module mem_wb_stage #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_result,
  input  logic [XLEN-1:0] addr_result,
  input  logic [4:0]      rd_in,
  input  logic [1:0]      ex_mem_op,
  input  logic [XLEN-1:0] ex_store_data,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_en,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            misalign_err,
  output logic            bus_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, MEM, WB} state_t;
  state_t          r_state, w_next;
  logic [XLEN-1:0] r_addr, r_wdata, r_data;
  logic [4:0]      r_rd;
  logic            r_we, r_mis, r_bus;
  logic [CW-1:0]   r_cnt;
  logic            w_accept, w_mem, w_mis, w_in_mem, w_ack, w_tmo;
  always_comb begin
    ex_ready   = !rst && (r_state == IDLE || r_state == WB);
    w_accept   = ex_valid && ex_ready;
    w_mem      = ex_mem_op == 2'b01 || ex_mem_op == 2'b10;
    w_mis      = w_mem && |addr_result[1:0];
    w_in_mem   = r_state == MEM;
    w_ack      = w_in_mem && dmem_ack;
    w_tmo      = w_in_mem && !dmem_ack && r_cnt == CW'(TIMEOUT - 1);
    w_next     = w_accept ? (!w_mem ? WB : w_mis ? IDLE : MEM) :
                 r_state == WB ? IDLE :
                 w_ack ? (r_we ? IDLE : WB) :
                 w_tmo ? IDLE : r_state;
    dmem_req   = w_in_mem;
    dmem_we    = w_in_mem && r_we;
    dmem_addr  = w_in_mem ? r_addr : '0;
    dmem_wdata = w_in_mem ? r_wdata : '0;
    wb_en      = r_state == WB;
    wb_rd      = wb_en ? r_rd : '0;
    wb_data    = wb_en ? r_data : '0;
    misalign_err = r_mis;
    bus_err      = r_bus;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_data  <= '0;
      r_rd    <= '0;
      r_we    <= 1'b0;
      r_mis   <= 1'b0;
      r_bus   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_mis   <= w_accept && w_mis;
      r_bus   <= w_tmo;
      r_cnt   <= w_in_mem ? r_cnt + 1'b1 : '0;
      if (w_accept) begin
        r_addr  <= addr_result;
        r_wdata <= ex_store_data;
        r_rd    <= rd_in;
        r_we    <= ex_mem_op == 2'b10;
        r_data  <= ex_result;
      end
      if (w_ack) r_data <= dmem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed scenario tests for mem_wb_stage with TIMEOUT=8.
module tb_mem_wb_stage;
  logic        clk = 0, rst = 1, ex_valid = 0, dmem_ack = 0;
  logic [31:0] ex_result = 0, addr_result = 0, ex_store_data = 0, dmem_rdata = 0;
  logic [4:0]  rd_in = 0;
  logic [1:0]  ex_mem_op = 0;
  logic        ex_ready, dmem_req, dmem_we, wb_en, misalign_err, bus_err;
  logic [31:0] dmem_addr, dmem_wdata, wb_data;
  logic [4:0]  wb_rd;
  int checks = 0, errors = 0;

  mem_wb_stage #(.XLEN(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result),
    .addr_result(addr_result), .rd_in(rd_in), .ex_mem_op(ex_mem_op), .ex_store_data(ex_store_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign_err(misalign_err), .bus_err(bus_err));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick;
    tick;
    checks++; if ({ex_ready, dmem_req, wb_en, misalign_err, bus_err} !== 5'b0) begin errors++; $display("FAIL reset_outs got %b exp 00000", {ex_ready, dmem_req, wb_en, misalign_err, bus_err}); end
    rst = 0;
    #1;
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ex_ready); end
  endtask

  task automatic test_alu_stream;
    for (int i = 0; i < 4; i++) begin
      ex_valid = 1; ex_mem_op = 2'b00; ex_result = 32'h3F800000 + i; rd_in = 5'(i + 1);
      checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL alu_ready[%0d] got %b exp 1", i, ex_ready); end
      tick;
      checks++; if ({wb_en, wb_rd, wb_data} !== {1'b1, 5'(i + 1), 32'h3F800000 + i}) begin errors++; $display("FAIL alu_wb[%0d] got %b/%0d/%h exp 1/%0d/%h", i, wb_en, wb_rd, wb_data, i + 1, 32'h3F800000 + i); end
    end
    ex_valid = 0;
    tick;
    checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL alu_wb_end got %b exp 0", wb_en); end
  endtask

  task automatic test_load;
    ex_valid = 1; ex_mem_op = 2'b01; addr_result = 32'h100; rd_in = 5'd7; ex_result = 32'h11111111;
    tick;
    ex_valid = 0;
    for (int k = 0; k < 3; k++) begin
      checks++; if ({dmem_req, dmem_we, dmem_addr, ex_ready, wb_en} !== {1'b1, 1'b0, 32'h100, 1'b0, 1'b0}) begin errors++; $display("FAIL load_mem[%0d] got req=%b we=%b addr=%h rdy=%b wb=%b exp 1 0 100 0 0", k, dmem_req, dmem_we, dmem_addr, ex_ready, wb_en); end
      dmem_ack = (k == 2); dmem_rdata = 32'h40490FDB;
      tick;
    end
    dmem_ack = 0;
    checks++; if ({dmem_req, wb_en, wb_rd, wb_data} !== {1'b0, 1'b1, 5'd7, 32'h40490FDB}) begin errors++; $display("FAIL load_wb got req=%b wb=%b rd=%0d data=%h exp 0 1 7 40490fdb", dmem_req, wb_en, wb_rd, wb_data); end
    tick;
    checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL load_wb_end got %b exp 0", wb_en); end
  endtask

  task automatic test_store;
    ex_valid = 1; ex_mem_op = 2'b10; addr_result = 32'h104; ex_store_data = 32'hC0000000; rd_in = 5'd3;
    tick;
    ex_valid = 0;
    checks++; if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== {1'b1, 1'b1, 32'h104, 32'hC0000000}) begin errors++; $display("FAIL store_req got %b %b %h %h exp 1 1 104 c0000000", dmem_req, dmem_we, dmem_addr, dmem_wdata); end
    dmem_ack = 1;
    tick;
    dmem_ack = 0;
    checks++; if ({dmem_req, wb_en, ex_ready} !== 3'b001) begin errors++; $display("FAIL store_done got %b exp 001", {dmem_req, wb_en, ex_ready}); end
    tick;
    checks++; if ({dmem_req, wb_en} !== 2'b00) begin errors++; $display("FAIL store_idle got %b exp 00", {dmem_req, wb_en}); end
  endtask

  task automatic test_misalign;
    ex_valid = 1; ex_mem_op = 2'b01; addr_result = 32'h102; rd_in = 5'd4;
    tick;
    ex_valid = 0;
    checks++; if ({misalign_err, dmem_req, ex_ready, wb_en} !== 4'b1010) begin errors++; $display("FAIL misalign_pulse got %b exp 1010", {misalign_err, dmem_req, ex_ready, wb_en}); end
    tick;
    checks++; if ({misalign_err, dmem_req, wb_en} !== 3'b000) begin errors++; $display("FAIL misalign_end got %b exp 000", {misalign_err, dmem_req, wb_en}); end
  endtask

  task automatic test_timeout;
    int n = 0;
    ex_valid = 1; ex_mem_op = 2'b01; addr_result = 32'h200; rd_in = 5'd5;
    tick;
    ex_valid = 0;
    for (int k = 0; k < 20 && dmem_req; k++) begin
      n++;
      checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL timeout_early_err[%0d] got 1 exp 0", k); end
      tick;
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL timeout_req_cycles got %0d exp 8", n); end
    checks++; if ({bus_err, wb_en, ex_ready, dmem_req} !== 4'b1010) begin errors++; $display("FAIL timeout_pulse got %b exp 1010", {bus_err, wb_en, ex_ready, dmem_req}); end
    dmem_ack = 1; dmem_rdata = 32'hAAAA5555;
    tick;
    dmem_ack = 0;
    checks++; if ({bus_err, dmem_req, wb_en} !== 3'b000) begin errors++; $display("FAIL timeout_late_ack got %b exp 000", {bus_err, dmem_req, wb_en}); end
    tick;
    checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL timeout_no_wb got %b exp 0", wb_en); end
  endtask

  task automatic test_reset_mid_mem;
    ex_valid = 1; ex_mem_op = 2'b10; addr_result = 32'h300; ex_store_data = 32'h1;
    tick;
    ex_valid = 0;
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rstmid_req got %b exp 1", dmem_req); end
    rst = 1;
    tick;
    checks++; if ({dmem_req, ex_ready, wb_en, bus_err, misalign_err, dmem_addr} !== {5'b0, 32'h0}) begin errors++; $display("FAIL rstmid_outs got %b %h exp 00000 0", {dmem_req, ex_ready, wb_en, bus_err, misalign_err}, dmem_addr); end
    rst = 0;
    ex_valid = 1; ex_mem_op = 2'b00; ex_result = 32'hDEADBEEF; rd_in = 5'd0;
    #1;
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b exp 1", ex_ready); end
    tick;
    ex_valid = 0;
    checks++; if ({wb_en, wb_rd, wb_data, bus_err} !== {1'b1, 5'd0, 32'hDEADBEEF, 1'b0}) begin errors++; $display("FAIL rstmid_next_op got %b %0d %h %b exp 1 0 deadbeef 0", wb_en, wb_rd, wb_data, bus_err); end
    tick;
  endtask

  task automatic test_back_to_back;
    ex_valid = 1; ex_mem_op = 2'b11; ex_result = 32'h01234567; rd_in = 5'd2; addr_result = 32'h3;
    tick;
    checks++; if ({wb_en, wb_rd, wb_data, dmem_req, misalign_err} !== {1'b1, 5'd2, 32'h01234567, 2'b00}) begin errors++; $display("FAIL b2b_op11 got %b %0d %h %b %b exp 1 2 01234567 0 0", wb_en, wb_rd, wb_data, dmem_req, misalign_err); end
    ex_mem_op = 2'b01; addr_result = 32'h400; rd_in = 5'd9; ex_result = 32'h0;
    tick;
    ex_valid = 0;
    checks++; if ({dmem_req, dmem_we, dmem_addr, wb_en} !== {2'b10, 32'h400, 1'b0}) begin errors++; $display("FAIL b2b_load_req got %b %b %h %b exp 1 0 400 0", dmem_req, dmem_we, dmem_addr, wb_en); end
    dmem_ack = 1; dmem_rdata = 32'h12345678;
    tick;
    dmem_ack = 0;
    checks++; if ({wb_en, wb_rd, wb_data} !== {1'b1, 5'd9, 32'h12345678}) begin errors++; $display("FAIL b2b_load_wb got %b %0d %h exp 1 9 12345678", wb_en, wb_rd, wb_data); end
    tick;
  endtask

  initial begin
    test_reset;
    test_alu_stream;
    test_load;
    test_store;
    test_misalign;
    test_timeout;
    test_reset_mid_mem;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
